// File: rtl/alarm_register_bank.sv
// Multi-slot BCD alarm store with validated loads, registered readback,
// minute-edge matching and a ring FSM with ack / timeout.
module alarm_register_bank #(
  parameter int NUM_ALARMS   = 4,
  parameter int IDX_W        = 2,
  parameter int RING_MINUTES = 5,
  parameter int RING_W       = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_new_a,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [3:0]       new_alarm_ls_min,
  input  logic [3:0]       new_alarm_ms_min,
  input  logic [3:0]       new_alarm_ls_hr,
  input  logic [3:0]       new_alarm_ms_hr,
  input  logic             new_alarm_AM,
  input  logic             new_alarm_en,
  output logic             load_err,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [3:0]       rd_ls_min,
  output logic [3:0]       rd_ms_min,
  output logic [3:0]       rd_ls_hr,
  output logic [3:0]       rd_ms_hr,
  output logic             rd_AM,
  output logic             rd_en,
  input  logic [3:0]       current_time_ls_min,
  input  logic [3:0]       current_time_ms_min,
  input  logic [3:0]       current_time_ls_hr,
  input  logic [3:0]       current_time_ms_hr,
  input  logic             current_time_AM,
  input  logic             minute_tick,
  input  logic             alarm_ack,
  output logic             alarm_ring,
  output logic [IDX_W-1:0] alarm_slot,
  output logic             match_pulse
);

  typedef struct packed {
    logic [3:0] ls_min;
    logic [3:0] ms_min;
    logic [3:0] ls_hr;
    logic [3:0] ms_hr;
    logic       am;
  } btime_t;

  typedef enum logic {
    IDLE,
    RINGING
  } state_t;

  localparam logic [IDX_W:0] NUM_L =
    (IDX_W+1)'(NUM_ALARMS);
  localparam logic [RING_W-1:0] RING_LAST =
    RING_W'(RING_MINUTES - 1);

  btime_t                slot_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;
  btime_t                prev_q;
  btime_t                cur;
  btime_t                new_t;
  btime_t                rd_sel;
  logic                  rd_sel_en;
  logic                  idx_ok;
  logic                  min_ok;
  logic                  hr_ok;
  logic                  load_ok;
  logic                  time_changed;
  logic [NUM_ALARMS-1:0] hit;
  logic                  any_hit;
  logic [IDX_W-1:0]      win;
  state_t                state_q;
  logic [RING_W-1:0]     ring_cnt;

  assign cur = '{
    ls_min: current_time_ls_min,
    ms_min: current_time_ms_min,
    ls_hr:  current_time_ls_hr,
    ms_hr:  current_time_ms_hr,
    am:     current_time_AM
  };

  assign new_t = '{
    ls_min: new_alarm_ls_min,
    ms_min: new_alarm_ms_min,
    ls_hr:  new_alarm_ls_hr,
    ms_hr:  new_alarm_ms_hr,
    am:     new_alarm_AM
  };

  // Load validation: index range, BCD minutes and 12-hour BCD hours
  assign idx_ok = {1'b0, load_idx} < NUM_L;
  assign min_ok = (new_alarm_ls_min <= 4'd9)
               && (new_alarm_ms_min <= 4'd5);

  // Legal ls_hr range depends on the tens digit
  always_comb begin
    hr_ok = 1'b0;
    unique case (1'b1)
      new_alarm_ms_hr == 4'd0:
        hr_ok = (new_alarm_ls_hr != 4'd0)
             && (new_alarm_ls_hr <= 4'd9);
      new_alarm_ms_hr == 4'd1:
        hr_ok = new_alarm_ls_hr <= 4'd2;
      default:
        hr_ok = 1'b0;
    endcase
  end

  assign load_ok = idx_ok && min_ok && hr_ok;

  // Slot storage; rejected loads leave every slot untouched
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_q[i] <= '0;
        en_q[i]   <= 1'b0;
      end
    end else if (load_new_a && load_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (load_idx == IDX_W'(i)) begin
          slot_q[i] <= new_t;
          en_q[i]   <= new_alarm_en;
        end
      end
    end
  end

  // Reject flag is a one-cycle pulse after a bad load request
  always_ff @(posedge clock) begin
    if (reset) load_err <= 1'b0;
    else       load_err <= load_new_a && !load_ok;
  end

  // Readback mux; out-of-range indices select zeros
  always_comb begin
    rd_sel    = '0;
    rd_sel_en = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_sel    = slot_q[i];
        rd_sel_en = en_q[i];
      end
    end
  end

  // Registered readback sees pre-write contents on a same-cycle load
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ls_min <= '0;
      rd_ms_min <= '0;
      rd_ls_hr  <= '0;
      rd_ms_hr  <= '0;
      rd_AM     <= 1'b0;
      rd_en     <= 1'b0;
    end else begin
      rd_ls_min <= rd_sel.ls_min;
      rd_ms_min <= rd_sel.ms_min;
      rd_ls_hr  <= rd_sel.ls_hr;
      rd_ms_hr  <= rd_sel.ms_hr;
      rd_AM     <= rd_sel.am;
      rd_en     <= rd_sel_en;
    end
  end

  // Previous time gives the edge that arms a match exactly once
  always_ff @(posedge clock) begin
    if (reset) prev_q <= '0;
    else       prev_q <= cur;
  end

  assign time_changed = cur != prev_q;

  // Per-slot hit on the cycle the time changes onto its value
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      hit[i] = en_q[i] && time_changed
            && (slot_q[i] == cur);
    end
  end

  // Lowest-index hit wins
  always_comb begin
    win     = '0;
    any_hit = 1'b0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win     = IDX_W'(i);
        any_hit = 1'b1;
      end
    end
  end

  // Ring FSM: start on hit, stop on ack or after the minute budget
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      alarm_ring  <= 1'b0;
      alarm_slot  <= '0;
      ring_cnt    <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_hit) begin
            state_q     <= RINGING;
            alarm_ring  <= 1'b1;
            alarm_slot  <= win;
            ring_cnt    <= '0;
            match_pulse <= 1'b1;
          end
        end
        RINGING: begin
          if (alarm_ack) begin
            state_q    <= IDLE;
            alarm_ring <= 1'b0;
          end else if (minute_tick) begin
            if (ring_cnt == RING_LAST) begin
              state_q    <= IDLE;
              alarm_ring <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + RING_W'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          alarm_ring <= 1'b0;
        end
      endcase
    end
  end

endmodule
